// File: rtl/vib_capture_ctrl.sv
// Triggered circular capture buffer sequencer: records samples into a sync RAM,
// freezes a programmable number of samples after the trigger, then drains them oldest-first.
module vib_capture_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] post_len,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_trig,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic [DATA_WIDTH-1:0] ram_di,
    output logic [ADDR_WIDTH-1:0] ram_r_addr,
    input  logic [DATA_WIDTH-1:0] ram_do,
    output logic [1:0]            state,
    output logic                  done
);

    // state | meaning
    // IDLE  | waiting for arm; samples dropped
    // ARMED | recording every sample, watching for a qualified trigger
    // POST  | recording post-trigger samples, post_cnt counting down
    // DRAIN | buffer frozen, streaming oldest-first to the consumer
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   FILL_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q, state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_nxt;
    logic [ADDR_WIDTH:0]   fill, fill_nxt;
    logic [ADDR_WIDTH-1:0] post_len_q;
    logic [ADDR_WIDTH-1:0] post_cnt;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  rd_pend;
    logic                  done_nxt;
    logic                  wr_en, arm_ok, trig_hit, post_wr, pop, rd_issue, enter_drain;

    assign wr_en      = s_valid && (state_q == ST_ARMED || state_q == ST_POST);
    assign wr_ptr_nxt = wr_en ? wr_ptr + PTR_ONE : wr_ptr;
    assign fill_nxt   = (wr_en && fill != FILL_MAX) ? fill + CNT_ONE : fill;

    assign arm_ok   = (state_q == ST_IDLE) && arm && !abort;
    assign trig_hit = (state_q == ST_ARMED) && s_valid && s_trig;
    assign post_wr  = (state_q == ST_POST) && s_valid;
    assign pop      = m_valid && m_ready;
    assign rd_issue = (state_q == ST_DRAIN) && !abort && (remaining != '0) && !rd_pend
                      && (!m_valid || m_ready);
    assign enter_drain = (state_nxt == ST_DRAIN) && (state_q != ST_DRAIN);

    assign ram_en     = 1'b1;
    assign ram_we     = wr_en;
    assign ram_w_addr = wr_ptr;
    assign ram_di     = s_data;
    assign ram_r_addr = rd_ptr;
    assign m_last     = m_valid && (remaining == '0) && !rd_pend;
    assign state      = state_q;

    always_comb begin
        state_nxt = state_q;
        done_nxt  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (trig_hit) state_nxt = (post_len_q == '0) ? ST_DRAIN : ST_POST;
            end
            ST_POST: begin
                if (post_wr && post_cnt == PTR_ONE) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // second term only covers an empty buffer, which normal capture never produces
                if ((pop && m_last) || (remaining == '0 && !rd_pend && !m_valid)) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr     <= '0;
            fill       <= '0;
            post_len_q <= '0;
            post_cnt   <= '0;
            rd_ptr     <= '0;
            remaining  <= '0;
            rd_pend    <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            done       <= 1'b0;
        end else begin
            state_q <= state_nxt;
            done    <= done_nxt;

            // post_len already fits in DEPTH-1, so the trigger sample can never be overwritten
            if (arm_ok) begin
                wr_ptr     <= '0;
                fill       <= '0;
                post_len_q <= post_len;
            end else begin
                wr_ptr <= wr_ptr_nxt;
                fill   <= fill_nxt;
            end

            if (trig_hit)     post_cnt <= post_len_q;
            else if (post_wr) post_cnt <= post_cnt - PTR_ONE;

            if (enter_drain) begin
                remaining <= fill_nxt;
                rd_ptr    <= wr_ptr_nxt - fill_nxt[ADDR_WIDTH-1:0];
            end else if (rd_issue) begin
                remaining <= remaining - CNT_ONE;
                rd_ptr    <= rd_ptr + PTR_ONE;
            end

            if (abort) begin
                rd_pend <= 1'b0;
                m_valid <= 1'b0;
            end else begin
                rd_pend <= rd_issue;
                if (rd_pend) begin
                    m_data  <= ram_do;
                    m_valid <= 1'b1;
                end else if (pop) begin
                    m_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vib_capture_ctrl.sv
// Randomized bench for vib_capture_ctrl: expected drain contents come from the
// "last DEPTH samples written since arm, ending post_len samples after the trigger" rule.
module tb_vib_capture_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n, arm, abort, s_valid, s_trig, m_ready;
    logic [AW-1:0] post_len;
    logic [DW-1:0] s_data;
    logic          m_valid, m_last, ram_en, ram_we, done;
    logic [DW-1:0] m_data, ram_di, ram_do;
    logic [AW-1:0] ram_w_addr, ram_r_addr;
    logic [1:0]    state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] got_q[$];
    logic          last_q[$];
    int            done_cnt = 0;
    bit            mon_prev_stall = 1'b0;
    logic [DW-1:0] mon_prev_data = '0;
    logic [DW-1:0] mem [DEPTH];

    vib_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .post_len(post_len),
        .s_valid(s_valid), .s_data(s_data), .s_trig(s_trig),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_w_addr(ram_w_addr), .ram_di(ram_di),
        .ram_r_addr(ram_r_addr), .ram_do(ram_do), .state(state), .done(done)
    );

    always #5 clk = ~clk;

    // synchronous RAM, read data one cycle after the address
    always @(posedge clk) begin
        if (ram_en && ram_we) mem[ram_w_addr] <= ram_di;
        if (ram_en) ram_do <= mem[ram_r_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !abort) begin
                if (mon_prev_stall) begin
                    check_eq("hold_valid", 32'(m_valid), 32'd1);
                    check_eq("hold_data", 32'(m_data), 32'(mon_prev_data));
                end
                mon_prev_stall = m_valid && !m_ready;
                mon_prev_data  = m_data;
                if (m_valid && m_ready) begin
                    got_q.push_back(m_data);
                    last_q.push_back(m_last);
                end
                if (done) done_cnt++;
                if (state == 2'd3 && s_valid) check_eq("we_in_drain", 32'(ram_we), 32'd0);
            end else begin
                mon_prev_stall = 1'b0;
            end
        end
    end

    task automatic run_capture(input int plen, input int pre, input logic [DW-1:0] base,
                               input bit rnd, input int stall_at, input string tag);
        logic [DW-1:0] data[$];
        logic [DW-1:0] exp[$];
        int  nsamp, e, first, i, stall, cyc, ones;
        bit  finished;
        nsamp = pre + plen + (rnd ? 5 : 2);
        e     = pre + plen;
        first = (e > DEPTH - 1) ? e - (DEPTH - 1) : 0;
        for (int k = 0; k < nsamp; k++) data.push_back(rnd ? DW'($urandom) : base + DW'(k));
        for (int k = first; k <= e; k++) exp.push_back(data[k]);
        got_q.delete();
        last_q.delete();
        done_cnt = 0;

        arm = 1'b1;
        post_len = AW'(plen);
        tick();
        arm = 1'b0;

        i = 0; stall = 0; cyc = 0; finished = 1'b0;
        while (cyc < 3000 && !finished) begin
            s_valid = 1'b0;
            s_trig  = 1'b0;
            arm     = rnd && (i < pre) && ($urandom_range(0, 5) == 0);
            if (i < nsamp && (!rnd || $urandom_range(0, 3) != 0)) begin
                s_valid = 1'b1;
                s_data  = data[i];
                s_trig  = (i == pre) || (rnd && i > pre && $urandom_range(0, 1) == 1);
                i++;
            end else if (rnd) begin
                s_trig = ($urandom_range(0, 1) == 1);
            end
            if (stall_at >= 0 && got_q.size() >= stall_at && stall < 10) begin
                m_ready = 1'b0;
                stall++;
            end else begin
                m_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            tick();
            cyc++;
            if (i >= nsamp && done_cnt > 0) finished = 1'b1;
        end
        s_valid = 1'b0;
        s_trig  = 1'b0;
        arm     = 1'b0;
        m_ready = 1'b1;
        repeat (3) tick();

        check_eq({tag, "_timeout"}, 32'(finished), 32'd1);
        check_eq({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check_eq({tag, "_state"}, 32'(state), 32'd0);
        check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < got_q.size(); k++)
            check_eq({tag, "_word"}, 32'(got_q[k]), 32'(exp[k]));
        ones = 0;
        foreach (last_q[k]) if (last_q[k]) ones++;
        check_eq({tag, "_last_cnt"}, 32'(ones), 32'd1);
        if (last_q.size() > 0) check_eq({tag, "_last_pos"}, 32'(last_q[last_q.size()-1]), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0; post_len = '0;
        s_valid = 1'b1; s_data = 8'hEE; s_trig = 1'b1; m_ready = 1'b1;
        repeat (3) tick();
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_m_last", 32'(m_last), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_m_data", 32'(m_data), 32'd0);
        check_eq("rst_ram_we", 32'(ram_we), 32'd0);
        check_eq("rst_r_addr", 32'(ram_r_addr), 32'd0);
        check_eq("ram_en", 32'(ram_en), 32'd1);
        rst_n = 1'b1;
        tick();
        check_eq("idle_drop_we", 32'(ram_we), 32'd0);
        s_valid = 1'b0; s_trig = 1'b0;

        arm = 1'b1; abort = 1'b1;
        tick();
        arm = 1'b0; abort = 1'b0;
        check_eq("arm_abort_idle", 32'(state), 32'd0);

        run_capture(3, 15, 8'h00, 1'b0, -1, "wrap");
        run_capture(2, 2, 8'hA0, 1'b0, -1, "partial");
        run_capture(0, 5, 8'h50, 1'b0, -1, "plen0");
        run_capture(4, 20, 8'h00, 1'b1, 5, "backpressure");

        // abort while collecting post-trigger samples
        done_cnt = 0;
        arm = 1'b1; post_len = 4'd5;
        tick();
        arm = 1'b0;
        s_valid = 1'b1; s_trig = 1'b1; s_data = 8'h77;
        tick();
        s_trig = 1'b0; s_data = 8'h78;
        tick();
        s_data = 8'h79;
        tick();
        check_eq("post_state", 32'(state), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_state", 32'(state), 32'd0);
        check_eq("abort_m_valid", 32'(m_valid), 32'd0);
        check_eq("abort_m_last", 32'(m_last), 32'd0);
        check_eq("abort_we", 32'(ram_we), 32'd0);
        s_valid = 1'b0;
        repeat (4) tick();
        check_eq("abort_no_done", 32'(done_cnt), 32'd0);

        // trigger without valid, re-arm while armed, then reset mid-drain
        arm = 1'b1; post_len = 4'd1;
        tick();
        arm = 1'b0; s_trig = 1'b1;
        tick();
        tick();
        check_eq("trig_no_valid", 32'(state), 32'd1);
        s_valid = 1'b1; s_data = 8'h30;
        tick();
        s_trig = 1'b0; s_data = 8'h31;
        tick();
        s_valid = 1'b0; m_ready = 1'b0;
        repeat (4) tick();
        check_eq("drain_state", 32'(state), 32'd3);
        check_eq("drain_valid", 32'(m_valid), 32'd1);
        check_eq("drain_oldest", 32'(m_data), 32'h30);
        rst_n = 1'b0; s_valid = 1'b1;
        tick();
        check_eq("mrst_state", 32'(state), 32'd0);
        check_eq("mrst_m_valid", 32'(m_valid), 32'd0);
        check_eq("mrst_m_last", 32'(m_last), 32'd0);
        check_eq("mrst_done", 32'(done), 32'd0);
        check_eq("mrst_m_data", 32'(m_data), 32'd0);
        check_eq("mrst_r_addr", 32'(ram_r_addr), 32'd0);
        check_eq("mrst_we", 32'(ram_we), 32'd0);
        rst_n = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
        tick();

        run_capture(6, 9, 8'hC0, 1'b0, -1, "after_reset");
        for (int r = 0; r < 10; r++)
            run_capture($urandom_range(0, 15), $urandom_range(0, 24), 8'h00, 1'b1,
                        ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1, "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
